// File: rtl/fetch_unit_pkg.sv
// Shared constants and helpers for the instruction-fetch stage.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] NOP_ENCODING = 32'h0000_0013;  // addi x0,x0,0

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, keeps at most one fetch in flight and offers {inst_out, pc_out}
// to IF_ID, absorbing hazard/memory stalls and EX redirects.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_VECTOR,
  parameter logic [31:0] NOP_INST = NOP_ENCODING
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PC_Write,
  input  logic        DStall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        IStall
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] tgt_q, tgt_d;
  logic        avail_s, adv_s;
  logic [31:0] inst_sel_s, redir_pc_s;

  always_comb begin
    avail_s    = (state_q == S_HOLD) || ((state_q == S_REQ) && imem_ready);
    adv_s      = avail_s && PC_Write && !DStall && !redirect_valid;
    inst_sel_s = (state_q == S_HOLD) ? buf_q : imem_rdata;
    redir_pc_s = word_align(redirect_pc);
  end

  assign imem_req  = (state_q != S_HOLD);
  assign imem_addr = pc_q;
  assign IStall    = !avail_s || redirect_valid;
  assign inst_out  = IStall ? NOP_INST : inst_sel_s;
  assign pc_out    = pc_q;

  // Redirect beats advance beats hold; pc only moves once the current request has completed.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    tgt_d   = tgt_q;
    case (state_q)
      S_REQ: begin
        if (redirect_valid && !imem_ready) begin
          tgt_d   = redir_pc_s;
          state_d = S_DROP;
        end else if (redirect_valid) begin
          pc_d = redir_pc_s;
        end else if (imem_ready && adv_s) begin
          pc_d = pc_q + 32'd4;
        end else if (imem_ready) begin
          buf_d   = imem_rdata;
          state_d = S_HOLD;
        end else begin
          state_d = S_REQ;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redir_pc_s;
          state_d = S_REQ;
        end else if (adv_s) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_REQ;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_DROP: begin
        // A redirect landing with the stale response still wins over the stored target.
        if (imem_ready) begin
          pc_d    = redirect_valid ? redir_pc_s : tgt_q;
          state_d = S_REQ;
        end else if (redirect_valid) begin
          tgt_d = redir_pc_s;
        end else begin
          state_d = S_DROP;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= word_align(RESET_PC);
      buf_q   <= 32'd0;
      tgt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      tgt_q   <= tgt_d;
    end
  end

endmodule
